// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: operation codes, ALUOp
// encodings, decode-field values, FSM states and default latencies.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1010;
    localparam logic [3:0] OP_ILL = 4'b1111;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // R-type decode field {funct7[0], funct7[5], funct3}
    localparam logic [4:0] FR_ADD = 5'b00000;
    localparam logic [4:0] FR_SUB = 5'b01000;
    localparam logic [4:0] FR_AND = 5'b00111;
    localparam logic [4:0] FR_OR  = 5'b00110;
    localparam logic [4:0] FR_XOR = 5'b00100;
    localparam logic [4:0] FR_SLL = 5'b00001;
    localparam logic [4:0] FR_SRL = 5'b00101;
    localparam logic [4:0] FR_SRA = 5'b01101;
    localparam logic [4:0] FR_SLT = 5'b00010;
    localparam logic [4:0] FR_MUL = 5'b10000;
    localparam logic [4:0] FR_DIV = 5'b10100;

    // I-type funct3
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SHR = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam int unsigned MUL_LAT_DEF = 3;
    localparam int unsigned DIV_LAT_DEF = 8;
    localparam int unsigned LAT_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of ALUOp/Funct into an operation code, illegal and
// multi-cycle flags, and the occupancy latency of multi-cycle operations.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned FUNCT_W = 5,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic [1:0]         ALUOp,
    input  logic [FUNCT_W-1:0] Funct,
    output logic [3:0]         code,
    output logic               illegal,
    output logic               multi,
    output logic [LAT_W-1:0]   lat
);

    logic [4:0] f5;

    assign f5 = Funct[4:0];

    always_comb begin
        code  = OP_ILL;
        multi = 1'b0;
        lat   = '0;
        case (ALUOp)
            ALUOP_MEM: code = OP_ADD;
            ALUOP_BR:  code = OP_SUB;
            ALUOP_R: begin
                case (f5)
                    FR_ADD: code = OP_ADD;
                    FR_SUB: code = OP_SUB;
                    FR_AND: code = OP_AND;
                    FR_OR:  code = OP_OR;
                    FR_XOR: code = OP_XOR;
                    FR_SLL: code = OP_SLL;
                    FR_SRL: code = OP_SRL;
                    FR_SRA: code = OP_SRA;
                    FR_SLT: code = OP_SLT;
                    FR_MUL: begin
                        code  = OP_MUL;
                        multi = 1'b1;
                        lat   = LAT_W'(MUL_LAT);
                    end
                    FR_DIV: begin
                        code  = OP_DIV;
                        multi = 1'b1;
                        lat   = LAT_W'(DIV_LAT);
                    end
                    default: code = OP_ILL;
                endcase
            end
            ALUOP_I: begin
                // Funct[4] never matters here; Funct[3] only selects SRL/SRA
                case (f5[2:0])
                    F3_ADD: code = OP_ADD;
                    F3_SLL: code = OP_SLL;
                    F3_SLT: code = OP_SLT;
                    F3_XOR: code = OP_XOR;
                    F3_SHR: code = f5[3] ? OP_SRA : OP_SRL;
                    F3_OR:  code = OP_OR;
                    F3_AND: code = OP_AND;
                    default: code = OP_ILL;
                endcase
            end
            default: code = OP_ILL;
        endcase
        illegal = (code == OP_ILL);
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: accepts decode requests, holds multi-cycle ops in
// BUSY for their latency, and presents results under a valid/ready handshake.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned FUNCT_W = 5,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         ALUOp,
    input  logic [FUNCT_W-1:0] Funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    Operation,
    output logic               illegal,
    output logic               multi,
    output logic               busy
);

    state_t            state, state_n;
    logic [LAT_W-1:0]  cnt, cnt_n;
    logic              accept;

    logic [3:0]        dec_code;
    logic              dec_illegal;
    logic              dec_multi;
    logic [LAT_W-1:0]  dec_lat;

    alu_ctrl_decode #(
        .FUNCT_W (FUNCT_W),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_decode (
        .ALUOp   (ALUOp),
        .Funct   (Funct),
        .code    (dec_code),
        .illegal (dec_illegal),
        .multi   (dec_multi),
        .lat     (dec_lat)
    );

    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);

    always_comb begin
        in_ready = (state == IDLE) || ((state == DONE) && out_ready);
        accept   = in_valid && in_ready && !flush;
        state_n  = state;
        cnt_n    = cnt;
        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE retires and re-accepts on the same edge when both handshakes fire
                    if (accept) begin
                        state_n = dec_multi ? BUSY : DONE;
                        cnt_n   = dec_multi ? (dec_lat - LAT_W'(1)) : '0;
                    end else if ((state == DONE) && out_ready) begin
                        state_n = IDLE;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state_n = DONE;
                    end else begin
                        cnt_n = cnt - LAT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            Operation <= '0;
            illegal   <= 1'b0;
            multi     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                Operation <= OP_W'(dec_code);
                illegal   <= dec_illegal;
                multi     <= dec_multi;
            end
        end
    end

endmodule
